// File: rtl/mtl_pkg.sv
// rtl/mtl_pkg.sv - shared types and address offsets for the MTL colour sequencer
package mtl_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic {IDLE, RUN} seq_state_t;

    // Offsets are relative to NUM_COLORS, directly above the palette entries
    localparam int ADDR_HOLD_OFS   = 0;
    localparam int ADDR_COMMIT_OFS = 1;
    localparam int HOLD_W_DEFAULT  = 8;

endpackage

// File: rtl/mtl_palette_regs.sv
// rtl/mtl_palette_regs.sv - shadow/active palette banks with end-of-frame commit copy
module mtl_palette_regs
    import mtl_pkg::*;
#(
    parameter int NUM_COLORS   = 4,
    parameter int ADDR_W       = 5,
    parameter int HOLD_W       = HOLD_W_DEFAULT,
    parameter int DEFAULT_HOLD = 60
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    end_frame_i,
    input  logic                    wr_valid_i,
    input  logic [ADDR_W-1:0]       wr_addr_i,
    input  rgb_t                    wr_data_i,
    output logic                    wr_ready_o,
    output logic                    commit_pending_o,
    output logic                    copy_o,
    output rgb_t [NUM_COLORS-1:0]   view_pal_o,
    output logic [HOLD_W-1:0]       view_hold_o
);

    localparam logic [ADDR_W-1:0] ADDR_HOLD   = ADDR_W'(NUM_COLORS + ADDR_HOLD_OFS);
    localparam logic [ADDR_W-1:0] ADDR_COMMIT = ADDR_W'(NUM_COLORS + ADDR_COMMIT_OFS);

    rgb_t [NUM_COLORS-1:0] shadow_pal_q;
    rgb_t [NUM_COLORS-1:0] active_pal_q;
    logic [HOLD_W-1:0]     shadow_hold_q;
    logic [HOLD_W-1:0]     active_hold_q;
    logic                  pending_q;
    logic                  wr_fire;

    // Writes stall only in the copy cycle so the copied shadow is never torn
    assign copy_o           = end_frame_i && pending_q;
    assign wr_ready_o       = !copy_o;
    assign wr_fire          = wr_valid_i && wr_ready_o;
    assign commit_pending_o = pending_q;

    // The sequencer sees the post-copy values when a new frame coincides with the copy
    assign view_pal_o  = copy_o ? shadow_pal_q  : active_pal_q;
    assign view_hold_o = copy_o ? shadow_hold_q : active_hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_pal_q  <= '0;
            active_pal_q  <= '0;
            shadow_hold_q <= HOLD_W'(DEFAULT_HOLD);
            active_hold_q <= HOLD_W'(DEFAULT_HOLD);
            pending_q     <= 1'b0;
        end else begin
            if (wr_fire) begin
                for (int i = 0; i < NUM_COLORS; i++) begin
                    if (wr_addr_i == ADDR_W'(i)) begin
                        shadow_pal_q[i] <= wr_data_i;
                    end
                end
                if (wr_addr_i == ADDR_HOLD) begin
                    shadow_hold_q <= wr_data_i[HOLD_W-1:0];
                end
                if (wr_addr_i == ADDR_COMMIT) begin
                    pending_q <= 1'b1;
                end
            end
            if (copy_o) begin
                active_pal_q  <= shadow_pal_q;
                active_hold_q <= shadow_hold_q;
                pending_q     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mtl_color_sequencer.sv
// rtl/mtl_color_sequencer.sv - frame-synchronous palette stepper feeding the MTL colour input
module mtl_color_sequencer
    import mtl_pkg::*;
#(
    parameter int NUM_COLORS   = 4,
    parameter int ADDR_W       = 5,
    parameter int HOLD_W       = HOLD_W_DEFAULT,
    parameter int DEFAULT_HOLD = 60
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iNewFrame,
    input  logic              iEndFrame,
    input  logic              iEnable,
    input  logic              iWrValid,
    output logic              oWrReady,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [23:0]       iWrData,
    output logic [23:0]       oColorData,
    output logic [3:0]        oIndex,
    output logic              oCommitPending,
    output logic [15:0]       oFrameCnt
);

    logic                  copy;
    rgb_t [NUM_COLORS-1:0] view_pal;
    logic [HOLD_W-1:0]     view_hold;

    seq_state_t        state_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [3:0]        idx_q;
    rgb_t              color_q;
    logic [15:0]       frame_cnt_q;

    logic [HOLD_W-1:0] cur_cnt;
    logic [HOLD_W-1:0] hold_m1;
    logic [3:0]        cur_idx;
    logic [3:0]        next_idx;

    mtl_palette_regs #(
        .NUM_COLORS   (NUM_COLORS),
        .ADDR_W       (ADDR_W),
        .HOLD_W       (HOLD_W),
        .DEFAULT_HOLD (DEFAULT_HOLD)
    ) u_regs (
        .clk_i            (iCLK),
        .rst_ni           (iRST_n),
        .end_frame_i      (iEndFrame),
        .wr_valid_i       (iWrValid),
        .wr_addr_i        (iWrAddr),
        .wr_data_i        (iWrData),
        .wr_ready_o       (oWrReady),
        .commit_pending_o (oCommitPending),
        .copy_o           (copy),
        .view_pal_o       (view_pal),
        .view_hold_o      (view_hold)
    );

    function automatic rgb_t pick(input rgb_t [NUM_COLORS-1:0] pal, input logic [3:0] idx);
        rgb_t c;
        c = '0;
        for (int i = 0; i < NUM_COLORS; i++) begin
            if (idx == 4'(i)) c = pal[i];
        end
        return c;
    endfunction

    // A commit copy restarts the schedule before any same-cycle frame step
    assign cur_idx  = copy ? 4'd0 : idx_q;
    assign cur_cnt  = copy ? '0 : cnt_q;
    assign hold_m1  = (view_hold == '0) ? '0 : view_hold - HOLD_W'(1);
    assign next_idx = (cur_idx == 4'(NUM_COLORS - 1)) ? 4'd0 : cur_idx + 4'd1;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            color_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            idx_q <= cur_idx;
            cnt_q <= cur_cnt;
            if (iNewFrame) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                case (state_q)
                    IDLE: begin
                        color_q <= '0;
                        if (iEnable) begin
                            state_q <= RUN;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            color_q <= pick(view_pal, 4'd0);
                        end
                    end
                    RUN: begin
                        if (!iEnable) begin
                            state_q <= IDLE;
                            color_q <= '0;
                        end else if (cur_cnt >= hold_m1) begin
                            cnt_q   <= '0;
                            idx_q   <= next_idx;
                            color_q <= pick(view_pal, next_idx);
                        end else begin
                            cnt_q   <= cur_cnt + HOLD_W'(1);
                            color_q <= pick(view_pal, cur_idx);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign oColorData = color_q;
    assign oIndex     = idx_q;
    assign oFrameCnt  = frame_cnt_q;

endmodule
